// File: rtl/galaksija_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : galaksija_reset_seq                                        |
// | Description : Releases the Galaksija core's active-low reset once the    |
// |               pixel PLL has been locked for a while. A debounced board   |
// |               reset button or a loss of PLL lock restarts the sequence.  |
// |               The whole block runs in the pixel clock domain.            |
// | Ports       : clk        pixel clock                                     |
// |               reset      synchronous active-high block reset             |
// |               locked_i   PLL lock (asynchronous, synchronised here)      |
// |               btn_n_i    raw active-low reset button (asynchronous)      |
// |               reset_n_o  registered active-low reset to the core         |
// |               led_o      registered status LED, high only in RUN         |
// |               state_o    registered state: 0 WAIT_LOCK 1 HOLD 2 RUN 3 BTN|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module galaksija_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE     = 1024,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_i,
  input  logic       btn_n_i,
  output logic       reset_n_o,
  output logic       led_o,
  output logic [1:0] state_o
);

  localparam int CNT_MAX = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    BTN       = 2'd3
  } state_t;

  // Input synchronisers. The button chain resets to 1 so a reset never
  // looks like a press.
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   btn_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n_i};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];

  // Debouncer: the synced button must disagree with the accepted value for
  // DEBOUNCE_CYCLES consecutive cycles before the new level is taken.
  logic              btn_db;
  logic [DCNT_W-1:0] dcnt;
  logic              press;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db <= 1'b1;
      dcnt   <= '0;
    end else if (btn_s == btn_db) begin
      dcnt <= '0;
    end else if (dcnt == DEB_LAST) begin
      btn_db <= btn_s;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // Press is a level: holding the button keeps the sequence parked in BTN.
  assign press = ~btn_db;

  // Sequencer
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s)                cnt_nx   = '0;
        else if (cnt == LOCK_LAST)  state_nx = HOLD;
        else                        cnt_nx   = cnt + CNT_W'(1);
      end
      HOLD: begin
        if (!lock_s)                state_nx = WAIT_LOCK;
        else if (press)             state_nx = BTN;
        else if (cnt == HOLD_LAST)  state_nx = RUN;
        else                        cnt_nx   = cnt + CNT_W'(1);
      end
      RUN: begin
        if (!lock_s)                state_nx = WAIT_LOCK;
        else if (press)             state_nx = BTN;
      end
      BTN: begin
        if (!lock_s)                state_nx = WAIT_LOCK;
        else if (btn_db)            state_nx = HOLD;
      end
      default:                      state_nx = WAIT_LOCK;
    endcase
    // Every state starts its count from zero.
    if (state_nx != state) cnt_nx = '0;
  end

  // Outputs are registered from the next state, so reset_n_o can only be
  // high while the registered state is RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      reset_n_o <= 1'b0;
      led_o     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      reset_n_o <= (state_nx == RUN);
      led_o     <= (state_nx == RUN);
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire
